// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the datapath (slave).
interface multicycle_control_fsm_if;
  // datapath -> sequencer
  logic [6:0]  opcode;
  logic        alu_bcond;
  logic [31:0] x17_value;
  logic        mem_ready;
  // sequencer -> datapath
  logic        pc_write;
  logic        pc_source;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        mdr_write;
  logic        ab_write;
  logic        aluout_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        instr_retired;
  logic        is_halted;

  modport master (
    input  opcode, alu_bcond, x17_value, mem_ready,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mdr_write,
           ab_write, aluout_write, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
           instr_retired, is_halted
  );

  modport slave (
    output opcode, alu_bcond, x17_value, mem_ready,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mdr_write,
           ab_write, aluout_write, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
           instr_retired, is_halted
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: IF/ID/EX/MEM/WB over a shared memory and ALU.
// Outputs are Mealy (state + mem_ready/alu_bcond) and forced low while reset is asserted.
module multicycle_control_fsm #(
  parameter logic [31:0] ECALL_HALT_CODE = 32'd10,
  parameter bit          ILLEGAL_HALTS   = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_fsm_if.master    bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_LD, S_JALR_WB, S_PCINC, S_HALT
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       aluout_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       instr_retired;
    logic       is_halted;
  } ctl_t;

  state_e state_q, state_d;
  ctl_t   ctl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    unique case (state_q)
      S_IF: begin
        ctl.mem_read = 1'b1;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          state_d      = S_ID;
        end
      end
      S_ID: begin
        // Branch/JAL target PC+imm is parked in ALUOut here for use in EX.
        ctl.ab_write     = 1'b1;
        ctl.aluout_write = 1'b1;
        ctl.alu_src_b    = 2'd2;
        if (bus.opcode == OP_SYSTEM)
          state_d = (bus.x17_value == ECALL_HALT_CODE) ? S_HALT : S_PCINC;
        else
          state_d = S_EX;
      end
      S_EX: begin
        unique case (bus.opcode)
          OP_R, OP_I: begin
            ctl.alu_src_a    = 1'b1;
            ctl.alu_src_b    = (bus.opcode == OP_I) ? 2'd2 : 2'd0;
            ctl.alu_op       = 2'd2;
            ctl.aluout_write = 1'b1;
            state_d          = S_WB_ALU;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            ctl.alu_src_a    = 1'b1;
            ctl.alu_src_b    = 2'd2;
            ctl.aluout_write = 1'b1;
            state_d          = (bus.opcode == OP_LOAD)  ? S_MEM_RD :
                               (bus.opcode == OP_STORE) ? S_MEM_WR : S_JALR_WB;
          end
          OP_BRANCH: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_op    = 2'd1;
            if (bus.alu_bcond) begin
              ctl.pc_write      = 1'b1;
              ctl.pc_source     = 1'b1;
              ctl.instr_retired = 1'b1;
              state_d           = S_IF;
            end else begin
              state_d = S_PCINC;
            end
          end
          OP_JAL: begin
            ctl.alu_src_b     = 2'd1;
            ctl.reg_write     = 1'b1;
            ctl.wb_sel        = 2'd2;
            ctl.pc_write      = 1'b1;
            ctl.pc_source     = 1'b1;
            ctl.instr_retired = 1'b1;
            state_d           = S_IF;
          end
          default: state_d = ILLEGAL_HALTS ? S_HALT : S_PCINC;
        endcase
      end
      S_MEM_RD: begin
        ctl.i_or_d   = 1'b1;
        ctl.mem_read = 1'b1;
        if (bus.mem_ready) begin
          ctl.mdr_write = 1'b1;
          state_d       = S_WB_LD;
        end
      end
      S_MEM_WR: begin
        ctl.i_or_d    = 1'b1;
        ctl.mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_PCINC;
      end
      S_WB_ALU: begin
        ctl.reg_write = 1'b1;
        state_d       = S_PCINC;
      end
      S_WB_LD: begin
        ctl.reg_write = 1'b1;
        ctl.wb_sel    = 2'd1;
        state_d       = S_PCINC;
      end
      S_JALR_WB: begin
        ctl.alu_src_b     = 2'd1;
        ctl.reg_write     = 1'b1;
        ctl.wb_sel        = 2'd2;
        ctl.pc_write      = 1'b1;
        ctl.pc_source     = 1'b1;
        ctl.instr_retired = 1'b1;
        state_d           = S_IF;
      end
      S_PCINC: begin
        ctl.alu_src_b     = 2'd1;
        ctl.pc_write      = 1'b1;
        ctl.instr_retired = 1'b1;
        state_d           = S_IF;
      end
      S_HALT: ctl.is_halted = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  // Reset gates every output combinationally so a pending write drops at once.
  assign {bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
          bus.ir_write, bus.mdr_write, bus.ab_write, bus.aluout_write, bus.alu_src_a,
          bus.alu_src_b, bus.alu_op, bus.reg_write, bus.wb_sel, bus.instr_retired,
          bus.is_halted} = reset ? ctl : '0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle output vectors checked against hand-derived patterns.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.ECALL_HALT_CODE(32'd10), .ILLEGAL_HALTS(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Layout: pw ps iod mr mw | irw mdr ab ao | sa sb[1:0] op[1:0] | rw wb[1:0] ret halt
  localparam logic [18:0] V_ZERO    = 19'b00000_0000_00000_00000;
  localparam logic [18:0] V_IF_RDY  = 19'b00010_1000_00000_00000;
  localparam logic [18:0] V_IF_WAIT = 19'b00010_0000_00000_00000;
  localparam logic [18:0] V_ID      = 19'b00000_0011_01000_00000;
  localparam logic [18:0] V_EX_R    = 19'b00000_0001_10010_00000;
  localparam logic [18:0] V_EX_AIMM = 19'b00000_0001_11000_00000;
  localparam logic [18:0] V_EX_BT   = 19'b11000_0000_10001_00010;
  localparam logic [18:0] V_EX_BN   = 19'b00000_0000_10001_00000;
  localparam logic [18:0] V_JUMP_WB = 19'b11000_0000_00100_11010;
  localparam logic [18:0] V_MRD_W   = 19'b00110_0000_00000_00000;
  localparam logic [18:0] V_MRD_R   = 19'b00110_0100_00000_00000;
  localparam logic [18:0] V_MWR     = 19'b00101_0000_00000_00000;
  localparam logic [18:0] V_WB_ALU  = 19'b00000_0000_00000_10000;
  localparam logic [18:0] V_WB_LD   = 19'b00000_0000_00000_10100;
  localparam logic [18:0] V_PCINC   = 19'b10000_0000_00100_00010;
  localparam logic [18:0] V_HALT    = 19'b00000_0000_00000_00001;

  logic [18:0] obs;

  function automatic logic [18:0] pack();
    return {bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mdr_write, bus.ab_write, bus.aluout_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.reg_write, bus.wb_sel, bus.instr_retired,
            bus.is_halted};
  endfunction

  task automatic step(input logic rdy, input logic bc);
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.alu_bcond = bc;
    #1;
    obs = pack();
  endtask

  task automatic test_reset();
    bus.opcode = 7'b0110011; bus.x17_value = 32'd0; bus.alu_bcond = 1'b0; bus.mem_ready = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== V_ZERO) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, V_ZERO);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1; obs = pack();
    checks++;
    if (obs !== V_IF_RDY) begin
      failures++;
      $display("FAIL reset_release_fetch: got %b expected %b", obs, V_IF_RDY);
    end
    bus.mem_ready = 1'b0;
    #1; obs = pack();
    checks++;
    if (obs !== V_IF_WAIT) begin
      failures++;
      $display("FAIL reset_release_wait: got %b expected %b", obs, V_IF_WAIT);
    end
  endtask

  task automatic test_add();
    logic [18:0] ev [6] = '{V_IF_RDY, V_ID, V_EX_R, V_WB_ALU, V_PCINC, V_IF_WAIT};
    bit          rv [6] = '{1, 1, 1, 1, 1, 0};
    bus.opcode = 7'b0110011;
    for (int i = 0; i < 6; i++) begin
      step(rv[i], 1'b0);
      checks++;
      if (obs !== ev[i]) begin
        failures++;
        $display("FAIL add cycle %0d: got %b expected %b", i + 1, obs, ev[i]);
      end
    end
  endtask

  task automatic test_load_stall();
    logic [18:0] ev [9] = '{V_IF_RDY, V_ID, V_EX_AIMM, V_MRD_W, V_MRD_W, V_MRD_R,
                            V_WB_LD, V_PCINC, V_IF_WAIT};
    bit          rv [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 0};
    bus.opcode = 7'b0000011;
    for (int i = 0; i < 9; i++) begin
      step(rv[i], 1'b0);
      checks++;
      if (obs !== ev[i]) begin
        failures++;
        $display("FAIL load cycle %0d: got %b expected %b", i + 1, obs, ev[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [18:0] ev [7] = '{V_IF_RDY, V_ID, V_EX_AIMM, V_MWR, V_MWR, V_PCINC, V_IF_WAIT};
    bit          rv [7] = '{1, 1, 1, 0, 1, 1, 0};
    bus.opcode = 7'b0100011;
    for (int i = 0; i < 7; i++) begin
      step(rv[i], 1'b0);
      checks++;
      if (obs !== ev[i]) begin
        failures++;
        $display("FAIL store cycle %0d: got %b expected %b", i + 1, obs, ev[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [18:0] et [4] = '{V_IF_RDY, V_ID, V_EX_BT, V_IF_WAIT};
    logic [18:0] en [5] = '{V_IF_RDY, V_ID, V_EX_BN, V_PCINC, V_IF_WAIT};
    bus.opcode = 7'b1100011;
    for (int i = 0; i < 4; i++) begin
      step(i != 3, 1'b1);
      checks++;
      if (obs !== et[i]) begin
        failures++;
        $display("FAIL beq_taken cycle %0d: got %b expected %b", i + 1, obs, et[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(i != 4, 1'b0);
      checks++;
      if (obs !== en[i]) begin
        failures++;
        $display("FAIL beq_not_taken cycle %0d: got %b expected %b", i + 1, obs, en[i]);
      end
    end
  endtask

  task automatic test_jal_jalr();
    logic [18:0] ej [4] = '{V_IF_RDY, V_ID, V_JUMP_WB, V_IF_WAIT};
    logic [18:0] er [5] = '{V_IF_RDY, V_ID, V_EX_AIMM, V_JUMP_WB, V_IF_WAIT};
    bus.opcode = 7'b1101111;
    for (int i = 0; i < 4; i++) begin
      step(i != 3, 1'b0);
      checks++;
      if (obs !== ej[i]) begin
        failures++;
        $display("FAIL jal cycle %0d: got %b expected %b", i + 1, obs, ej[i]);
      end
    end
    bus.opcode = 7'b1100111;
    for (int i = 0; i < 5; i++) begin
      step(i != 4, 1'b0);
      checks++;
      if (obs !== er[i]) begin
        failures++;
        $display("FAIL jalr cycle %0d: got %b expected %b", i + 1, obs, er[i]);
      end
    end
  endtask

  task automatic test_unknown_nop();
    logic [18:0] ev [5] = '{V_IF_RDY, V_ID, V_ZERO, V_PCINC, V_IF_WAIT};
    bus.opcode = 7'b1111111;
    for (int i = 0; i < 5; i++) begin
      step(i != 4, 1'b1);
      checks++;
      if (obs !== ev[i]) begin
        failures++;
        $display("FAIL unknown_op cycle %0d: got %b expected %b", i + 1, obs, ev[i]);
      end
    end
  endtask

  task automatic test_ecall_continue();
    logic [18:0] ev [4] = '{V_IF_RDY, V_ID, V_PCINC, V_IF_WAIT};
    bus.opcode = 7'b1110011;
    bus.x17_value = 32'd5;
    for (int i = 0; i < 4; i++) begin
      step(i != 3, 1'b0);
      checks++;
      if (obs !== ev[i]) begin
        failures++;
        $display("FAIL ecall_continue cycle %0d: got %b expected %b", i + 1, obs, ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [18:0] ev [4] = '{V_IF_RDY, V_ID, V_EX_AIMM, V_MWR};
    bus.opcode = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      step(i < 3, 1'b0);
      checks++;
      if (obs !== ev[i]) begin
        failures++;
        $display("FAIL midwrite_setup cycle %0d: got %b expected %b", i + 1, obs, ev[i]);
      end
    end
    reset = 1'b0;
    #1; obs = pack();
    checks++;
    if (obs !== V_ZERO) begin
      failures++;
      $display("FAIL midwrite_reset_drop: got %b expected %b", obs, V_ZERO);
    end
    @(negedge clk);
    reset = 1'b1;
    #1; obs = pack();
    checks++;
    if (obs !== V_IF_WAIT) begin
      failures++;
      $display("FAIL midwrite_refetch: got %b expected %b", obs, V_IF_WAIT);
    end
  endtask

  task automatic test_ecall_halt();
    logic [18:0] ev [2] = '{V_IF_RDY, V_ID};
    bus.opcode = 7'b1110011;
    bus.x17_value = 32'd10;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (obs !== ev[i]) begin
        failures++;
        $display("FAIL ecall_halt cycle %0d: got %b expected %b", i + 1, obs, ev[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, i[0]);
      checks++;
      if (obs !== V_HALT) begin
        failures++;
        $display("FAIL halt_sticky cycle %0d: got %b expected %b", i, obs, V_HALT);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1; obs = pack();
    checks++;
    if (obs !== V_ZERO) begin
      failures++;
      $display("FAIL halt_reset_clear: got %b expected %b", obs, V_ZERO);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1; obs = pack();
    checks++;
    if (obs !== V_IF_RDY) begin
      failures++;
      $display("FAIL halt_restart_fetch: got %b expected %b", obs, V_IF_RDY);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_stall();
    test_store();
    test_branch();
    test_jal_jalr();
    test_unknown_nop();
    test_ecall_continue();
    test_reset_mid_write();
    test_ecall_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
